// File: rtl/int_pkg.sv
// Shared types and constants for the interrupt/reset sequencer and control.
`timescale 1ns/1ps
package int_pkg;

  typedef enum logic [3:0] {
    RST_HOLD, RST_1, RST_2, RST_3, IDLE,
    PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI, LOAD
  } int_state_t;

  typedef enum logic [1:0] {
    KIND_NONE = 2'd0,
    KIND_IRQ  = 2'd1,
    KIND_NMI  = 2'd2,
    KIND_RST  = 2'd3
  } int_kind_t;

  localparam logic [15:0] VEC_NMI    = 16'hFFFA;
  localparam logic [15:0] VEC_RST    = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ    = 16'hFFFE;
  localparam logic [7:0]  STACK_PAGE = 8'h01;

  // P register bit positions
  localparam int P_I = 2;
  localparam int P_B = 4;
  localparam int P_U = 5;

  // P as it lands on the stack: unused bit reads 1, B marks a software BRK
  function automatic logic [7:0] push_p(input logic [7:0] p, input logic brk);
    logic [7:0] r;
    r      = p;
    r[P_U] = 1'b1;
    r[P_B] = brk;
    return r;
  endfunction

endpackage

// File: rtl/nmi_edge_detect.sv
// Two-flop synchronizer on nmi_n plus a one-cycle falling-edge pulse.
`timescale 1ns/1ps
module nmi_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic nmi_n,
  output logic nmi_fall
);

  logic sync0, sync1, prev;

  // synchronize the pin and keep one cycle of history for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0 <= 1'b1;
      sync1 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync0 <= nmi_n;
      sync1 <= sync0;
      prev  <= sync1;
    end
  end

  assign nmi_fall = prev & ~sync1;

endmodule

// File: rtl/int_sequencer.sv
// Reset / NMI / IRQ / BRK sequencer: owns the bus while it pushes PC and P,
// fetches the vector and hands the new PC back to control.
`timescale 1ns/1ps
module int_sequencer
  import int_pkg::*;
#(
  parameter logic [15:0] NMI_VEC = VEC_NMI,
  parameter logic [15:0] RST_VEC = VEC_RST,
  parameter logic [15:0] IRQ_VEC = VEC_IRQ
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nmi_n,
  input  logic        irq_n,
  input  logic        brk_req,
  input  logic        sync,
  input  logic [7:0]  p_in,
  input  logic [7:0]  s_in,
  input  logic [15:0] pc_in,
  input  logic [7:0]  din,
  output logic        busy,
  output logic [15:0] addr_out,
  output logic        addr_en,
  output logic [7:0]  dout,
  output logic        mem_rw,
  output logic        s_dec,
  output logic [15:0] pc_out,
  output logic        pc_ld,
  output logic        p_set_i,
  output logic [1:0]  int_kind
);

  int_state_t state, state_nxt;
  int_kind_t  kind_q;
  logic       nmi_fall, nmi_pend, brk_pend, is_brk;
  logic       irq_ok, nmi_hit, start, enter_vec;
  logic [7:0] vec_lo;
  logic [15:0] vec, stack_addr;

  nmi_edge_detect u_nmi (
    .clk      (clk),
    .rst_n    (rst_n),
    .nmi_n    (nmi_n),
    .nmi_fall (nmi_fall)
  );

  assign irq_ok     = ~irq_n & ~p_in[P_I];
  // an edge arriving on the selection cycle still counts, so late NMIs can hijack
  assign nmi_hit    = nmi_pend | nmi_fall;
  assign start      = (state == IDLE) && sync && (nmi_pend || brk_pend || irq_ok);
  assign enter_vec  = (state == RST_3) || (state == PUSH_P);
  assign stack_addr = {STACK_PAGE, s_in};
  assign int_kind   = kind_q;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RST_HOLD;
    else        state <= state_nxt;
  end

  // next-state sequencing
  always_comb begin
    state_nxt = state;
    case (state)
      RST_HOLD: state_nxt = RST_1;
      RST_1:    state_nxt = RST_2;
      RST_2:    state_nxt = RST_3;
      RST_3:    state_nxt = VEC_LO;
      IDLE:     if (start) state_nxt = PUSH_PCH;
      PUSH_PCH: state_nxt = PUSH_PCL;
      PUSH_PCL: state_nxt = PUSH_P;
      PUSH_P:   state_nxt = VEC_LO;
      VEC_LO:   state_nxt = VEC_HI;
      VEC_HI:   state_nxt = LOAD;
      LOAD:     state_nxt = IDLE;
      default:  state_nxt = RST_HOLD;
    endcase
  end

  // pending request flags; a new edge/request wins over a same-cycle clear
  // except when that edge is the one being serviced
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nmi_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else begin
      if ((state == PUSH_P) && nmi_hit) nmi_pend <= 1'b0;
      else if (nmi_fall)                nmi_pend <= 1'b1;
      if (brk_req)        brk_pend <= 1'b1;
      else if (enter_vec) brk_pend <= 1'b0;
    end
  end

  // per-sequence data: BRK flag for the pushed P, vector choice, vector low byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_brk <= 1'b0;
      kind_q <= KIND_NONE;
      vec_lo <= 8'h00;
    end else begin
      if (start) is_brk <= ~nmi_pend & brk_pend;
      if (enter_vec)
        kind_q <= (state == RST_3) ? KIND_RST : (nmi_hit ? KIND_NMI : KIND_IRQ);
      else if (state == LOAD)
        kind_q <= KIND_NONE;
      if (state == VEC_HI) vec_lo <= din;
    end
  end

  // vector address follows the latched source
  always_comb begin
    case (kind_q)
      KIND_NMI: vec = NMI_VEC;
      KIND_RST: vec = RST_VEC;
      default:  vec = IRQ_VEC;
    endcase
  end

  // bus and core-update outputs decoded from state
  always_comb begin
    busy     = 1'b1;
    addr_en  = 1'b1;
    mem_rw   = 1'b1;
    addr_out = 16'h0000;
    dout     = 8'h00;
    s_dec    = 1'b0;
    pc_out   = 16'h0000;
    pc_ld    = 1'b0;
    p_set_i  = 1'b0;
    case (state)
      RST_HOLD: addr_en = 1'b0;
      IDLE: begin
        busy    = 1'b0;
        addr_en = 1'b0;
      end
      RST_1, RST_2, RST_3: begin
        addr_out = stack_addr;
        s_dec    = 1'b1;
      end
      PUSH_PCH, PUSH_PCL, PUSH_P: begin
        addr_out = stack_addr;
        mem_rw   = 1'b0;
        s_dec    = 1'b1;
        dout     = (state == PUSH_PCH) ? pc_in[15:8] :
                   (state == PUSH_PCL) ? pc_in[7:0]  : push_p(p_in, is_brk);
      end
      VEC_LO: addr_out = vec;
      VEC_HI: addr_out = vec + 16'd1;
      LOAD: begin
        addr_out = vec + 16'd1;
        pc_out   = {din, vec_lo};
        pc_ld    = 1'b1;
        p_set_i  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_int_sequencer.sv
// Self-checking bench for int_sequencer: bus-cycle and PC-load scoreboards,
// a vector table of IRQ/BRK cases and hand-written reset/NMI corner sequences.
`timescale 1ns/1ps
module tb_int_sequencer;

  logic        clk, rst_n, nmi_n, irq_n, brk_req, sync;
  logic [7:0]  p_in, s_in, din;
  logic [15:0] pc_in;
  logic        busy, addr_en, mem_rw, s_dec, pc_ld, p_set_i;
  logic [15:0] addr_out, pc_out;
  logic [7:0]  dout;
  logic [1:0]  int_kind;

  int checks = 0;
  int failures = 0;
  logic seen_busy, seen_pc_ld;

  typedef struct packed {
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        sdec;
  } txn_t;

  typedef struct packed {
    logic [15:0] pc;
    logic [1:0]  kind;
  } ld_t;

  typedef struct packed {
    logic        brk;
    logic [15:0] pc;
    logic [7:0]  p;
    logic [7:0]  s;
    logic [7:0]  exp_p;
    logic [15:0] exp_vec;
    logic [1:0]  exp_kind;
    logic [15:0] exp_pc;
  } vec_t;

  txn_t exp_q[$];
  ld_t  exp_ld[$];
  vec_t tbl [0:4];

  int_sequencer dut (
    .clk(clk), .rst_n(rst_n), .nmi_n(nmi_n), .irq_n(irq_n), .brk_req(brk_req),
    .sync(sync), .p_in(p_in), .s_in(s_in), .pc_in(pc_in), .din(din),
    .busy(busy), .addr_out(addr_out), .addr_en(addr_en), .dout(dout),
    .mem_rw(mem_rw), .s_dec(s_dec), .pc_out(pc_out), .pc_ld(pc_ld),
    .p_set_i(p_set_i), .int_kind(int_kind)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    case (a)
      16'hFFFA: return 8'h00;
      16'hFFFB: return 8'h90;
      16'hFFFC: return 8'h34;
      16'hFFFD: return 8'h12;
      16'hFFFE: return 8'h00;
      16'hFFFF: return 8'h80;
      default:  return 8'h00;
    endcase
  endfunction

  // memory returns read data one cycle after the address
  always @(posedge clk) din <= mem_rd(addr_out);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    txn_t t;
    ld_t  l;
    if (rst_n && addr_en && !pc_ld) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL txn_unexpected actual addr=%h rw=%b required=no bus cycle", addr_out, mem_rw);
      end else begin
        t = exp_q.pop_front();
        check("txn_rw",   32'(mem_rw),   32'(t.rw));
        check("txn_addr", 32'(addr_out), 32'(t.addr));
        check("txn_sdec", 32'(s_dec),    32'(t.sdec));
        if (!t.rw) check("txn_dout", 32'(dout), 32'(t.data));
      end
    end
    if (rst_n && pc_ld) begin
      if (exp_ld.size() == 0) begin
        checks++; failures++;
        $display("FAIL load_unexpected actual pc_out=%h required=no load", pc_out);
      end else begin
        l = exp_ld.pop_front();
        check("load_pc",   32'(pc_out),   32'(l.pc));
        check("load_kind", 32'(int_kind), 32'(l.kind));
        check("load_seti", 32'(p_set_i),  32'd1);
      end
    end
  endtask

  // one clock: sample/score at negedge, then act as the core after the edge
  task automatic step();
    logic dec, seti;
    @(negedge clk);
    monitor();
    dec = s_dec; seti = p_set_i;
    seen_busy = busy; seen_pc_ld = pc_ld;
    @(posedge clk); #1;
    if (rst_n && dec)  s_in = s_in - 8'd1;
    if (rst_n && seti) p_in[2] = 1'b1;
  endtask

  task automatic push_vec(input logic [15:0] vec, input logic [1:0] kind, input logic [15:0] npc);
    exp_q.push_back('{1'b1, vec, 8'h00, 1'b0});
    exp_q.push_back('{1'b1, vec + 16'd1, 8'h00, 1'b0});
    exp_ld.push_back('{npc, kind});
  endtask

  task automatic push_rst(input logic [7:0] s0);
    logic [7:0] sa;
    sa = s0;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back('{1'b1, {8'h01, sa}, 8'h00, 1'b1});
      sa = sa - 8'd1;
    end
    push_vec(16'hFFFC, 2'd3, 16'h1234);
  endtask

  task automatic push_int(input logic [15:0] pc, input logic [7:0] s, input logic [7:0] pp,
                          input logic [15:0] vec, input logic [1:0] kind, input logic [15:0] npc);
    logic [7:0] sa;
    sa = s;
    exp_q.push_back('{1'b0, {8'h01, sa}, pc[15:8], 1'b1}); sa = sa - 8'd1;
    exp_q.push_back('{1'b0, {8'h01, sa}, pc[7:0],  1'b1}); sa = sa - 8'd1;
    exp_q.push_back('{1'b0, {8'h01, sa}, pp,       1'b1});
    push_vec(vec, kind, npc);
  endtask

  // run one sequence to IDLE; hijack drives NMI edges during and after it
  task automatic run_seq(input string nm, input bit hijack);
    int ld_at, idle_at;
    bit went;
    ld_at = 0; idle_at = 0; went = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (i == 1) begin sync = 1'b0; irq_n = 1'b1; end
      if (hijack) begin
        if (i == 1) nmi_n = 1'b0;
        if (i == 3) nmi_n = 1'b1;
        if (i == 5) nmi_n = 1'b0;
        if (i == 8) nmi_n = 1'b1;
      end
      if (seen_busy) went = 1;
      if (seen_pc_ld && ld_at == 0) ld_at = i;
      if (went && !seen_busy) begin idle_at = i; break; end
    end
    check({nm, "_ld_step"},   32'(ld_at),         32'd7);
    check({nm, "_idle_step"}, 32'(idle_at),       32'd8);
    check({nm, "_txn_left"},  32'(exp_q.size()),  32'd0);
    check({nm, "_ld_left"},   32'(exp_ld.size()), 32'd0);
  endtask

  task automatic quiet(input string nm, input int n);
    int hi;
    hi = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (seen_busy) hi++;
    end
    check(nm, 32'(hi), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b0, 16'hC012, 8'h81, 8'hFD, 8'hA1, 16'hFFFE, 2'd1, 16'h8000};
    tbl[1] = '{1'b1, 16'h0202, 8'h00, 8'hFF, 8'h30, 16'hFFFE, 2'd1, 16'h8000};
    tbl[2] = '{1'b0, 16'hFFFF, 8'hC3, 8'h02, 8'hE3, 16'hFFFE, 2'd1, 16'h8000};
    tbl[3] = '{1'b1, 16'h1234, 8'h04, 8'h00, 8'h34, 16'hFFFE, 2'd1, 16'h8000};
    tbl[4] = '{1'b0, 16'h5A5A, 8'h10, 8'h80, 8'h20, 16'hFFFE, 2'd1, 16'h8000};

    rst_n = 1'b0; nmi_n = 1'b1; irq_n = 1'b1; brk_req = 1'b0; sync = 1'b0;
    p_in = 8'h00; s_in = 8'h00; pc_in = 16'h0000;

    // reset state
    step(); step(); step();
    check("rst_busy",   32'(busy),     32'd1);
    check("rst_addren", 32'(addr_en),  32'd0);
    check("rst_rw",     32'(mem_rw),   32'd1);
    check("rst_sdec",   32'(s_dec),    32'd0);
    check("rst_pcld",   32'(pc_ld),    32'd0);
    check("rst_seti",   32'(p_set_i),  32'd0);
    check("rst_dout",   32'(dout),     32'd0);
    check("rst_addr",   32'(addr_out), 32'd0);
    check("rst_pcout",  32'(pc_out),   32'd0);
    check("rst_kind",   32'(int_kind), 32'd0);

    // power-on reset sequence from S=$00
    push_rst(s_in);
    rst_n = 1'b1;
    run_seq("reset", 0);

    // IRQ / BRK vector table
    for (int k = 0; k < 5; k++) begin
      pc_in = tbl[k].pc; p_in = tbl[k].p; s_in = tbl[k].s;
      push_int(tbl[k].pc, tbl[k].s, tbl[k].exp_p, tbl[k].exp_vec, tbl[k].exp_kind, tbl[k].exp_pc);
      if (tbl[k].brk) begin
        brk_req = 1'b1; step(); brk_req = 1'b0;
      end else begin
        irq_n = 1'b0;
      end
      sync = 1'b1;
      run_seq($sformatf("vec%0d", k), 0);
    end

    // masked IRQ never starts a sequence
    p_in = 8'h04; irq_n = 1'b0; sync = 1'b1;
    quiet("irq_masked_busy", 20);
    irq_n = 1'b1; sync = 1'b0;

    // NMI hijacks an IRQ; a second edge after VEC_LO stays pending
    pc_in = 16'h4000; p_in = 8'h00; s_in = 8'hFF;
    push_int(16'h4000, 8'hFF, 8'h20, 16'hFFFA, 2'd2, 16'h9000);
    irq_n = 1'b0; sync = 1'b1;
    run_seq("hijack", 1);
    quiet("hijack_no_sync_busy", 3);
    check("hijack_p_i_set", 32'(p_in), 32'h04);
    pc_in = 16'h9000;
    push_int(16'h9000, s_in, 8'h24, 16'hFFFA, 2'd2, 16'h9000);
    sync = 1'b1;
    run_seq("nmi2", 0);
    sync = 1'b1;
    quiet("nmi_cleared_busy", 6);
    sync = 1'b0;

    // BRK and NMI pend together: NMI serviced with B=0, BRK lost
    nmi_n = 1'b0; step(); step();
    brk_req = 1'b1; step(); brk_req = 1'b0; nmi_n = 1'b1;
    pc_in = 16'h0300; p_in = 8'h00; s_in = 8'hF0;
    push_int(16'h0300, 8'hF0, 8'h20, 16'hFFFA, 2'd2, 16'h9000);
    sync = 1'b1;
    run_seq("brk_nmi", 0);
    sync = 1'b1;
    quiet("brk_lost_busy", 6);
    sync = 1'b0;

    // reset in the middle of PUSH_PCL
    pc_in = 16'h7788; p_in = 8'h00; s_in = 8'hFF;
    exp_q.push_back('{1'b0, 16'h01FF, 8'h77, 1'b1});
    irq_n = 1'b0; sync = 1'b1;
    step();
    irq_n = 1'b1; sync = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("abort_busy",   32'(busy),          32'd1);
    check("abort_addren", 32'(addr_en),       32'd0);
    check("abort_rw",     32'(mem_rw),        32'd1);
    check("abort_kind",   32'(int_kind),      32'd0);
    check("abort_left",   32'(exp_q.size()),  32'd0);
    step(); step();
    push_rst(s_in);
    rst_n = 1'b1;
    run_seq("reset2", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
